// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC blocks: arctangent table, angle constants, FSM encodings.
package cordic_pkg;

  localparam int unsigned ATAN_DEPTH = 16;
  localparam int unsigned ATAN_IW    = 4;

  // atan(2^-i) as a 32-bit binary angle (2^32 == 360 degrees)
  localparam logic [31:0] ATAN_TABLE [0:ATAN_DEPTH-1] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };

  localparam logic [31:0] ANGLE_PI = 32'h8000_0000;
  localparam logic [31:0] CORDIC_K = 32'h6964_8541;  // ~1.646760 in Q2.30

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/cordic_vector_if.sv
// Launch/result bundle for the vectoring CORDIC (same launch convention as cordic_block).
interface cordic_vector_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic [31:0]      n;
  logic             busy;
  logic             done;
  logic [WIDTH+1:0] mag;
  logic [WIDTH-1:0] z;

  modport master (output valid, x0, y0, n, input busy, done, mag, z);
  modport slave  (input valid, x0, y0, n, output busy, done, mag, z);
endinterface

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: steers y toward zero and accumulates the angle.
module cordic_vec_stage #(
  parameter int unsigned XW = 34,
  parameter int unsigned ZW = 32,
  parameter int unsigned SW = 5
) (
  input  logic signed [XW-1:0] xr_i,
  input  logic signed [XW-1:0] yr_i,
  input  logic        [ZW-1:0] zr_i,
  input  logic        [SW-1:0] shift_i,
  input  logic        [ZW-1:0] atan_i,
  output logic signed [XW-1:0] xr_o,
  output logic signed [XW-1:0] yr_o,
  output logic        [ZW-1:0] zr_o
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;

  always_comb begin
    xs = xr_i >>> shift_i;
    ys = yr_i >>> shift_i;
    if (!yr_i[XW-1]) begin
      xr_o = xr_i + ys;
      yr_o = yr_i - xs;
      zr_o = zr_i + atan_i;
    end else begin
      xr_o = xr_i - ys;
      yr_o = yr_i + xs;
      zr_o = zr_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: returns K*|v| and atan2(y0, x0), one micro-rotation per clock.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ITER_MAX = 16
) (
  input logic             clk,
  input logic             rst_n,
  cordic_vector_if.slave  bus
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned CW = $clog2(ITER_MAX + 1);

  state_t               state_q, state_d;
  logic signed [XW-1:0] xr_q, xr_d, yr_q, yr_d;
  logic signed [XW-1:0] x_rot, y_rot, x_ext, y_ext;
  logic [WIDTH-1:0]     zr_q, zr_d, z_rot, z_q, z_d, atan_i;
  logic [CW-1:0]        i_q, i_d, neff_q, neff_d;
  logic [XW-1:0]        mag_q, mag_d;

  assign x_ext  = {{2{bus.x0[WIDTH-1]}}, bus.x0};
  assign y_ext  = {{2{bus.y0[WIDTH-1]}}, bus.y0};
  assign atan_i = ATAN_TABLE[ATAN_IW'(i_q)][31 -: WIDTH];

  cordic_vec_stage #(
    .XW (XW),
    .ZW (WIDTH),
    .SW (CW)
  ) u_stage (
    .xr_i    (xr_q),
    .yr_i    (yr_q),
    .zr_i    (zr_q),
    .shift_i (i_q),
    .atan_i  (atan_i),
    .xr_o    (x_rot),
    .yr_o    (y_rot),
    .zr_o    (z_rot)
  );

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    zr_d    = zr_q;
    i_d     = i_q;
    neff_d  = neff_q;
    mag_d   = mag_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          state_d = ST_RUN;
          i_d     = '0;
          neff_d  = (bus.n > 32'(ITER_MAX)) ? CW'(ITER_MAX) : CW'(bus.n);
          // Left half-plane: rotate by 180 degrees so x starts non-negative
          if (bus.x0[WIDTH-1]) begin
            xr_d = -x_ext;
            yr_d = -y_ext;
            zr_d = ANGLE_PI[31 -: WIDTH];
          end else begin
            xr_d = x_ext;
            yr_d = y_ext;
            zr_d = '0;
          end
        end
      end
      ST_RUN: begin
        if (i_q == neff_q) begin
          state_d = ST_DONE;
          mag_d   = xr_q;
          z_d     = zr_q;
        end else begin
          xr_d = x_rot;
          yr_d = y_rot;
          zr_d = z_rot;
          i_d  = i_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      zr_q    <= '0;
      i_q     <= '0;
      neff_q  <= '0;
      mag_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      zr_q    <= zr_d;
      i_q     <= i_d;
      neff_q  <= neff_d;
      mag_q   <= mag_d;
      z_q     <= z_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.mag  = mag_q;
  assign bus.z    = z_q;

endmodule
